// File: rtl/eeprom_ctrl_if.sv
// rtl/eeprom_ctrl_if.sv - command and array-port signal bundle for eeprom_ctrl
interface eeprom_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              req;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              busy;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_erase;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requester plus array side: issues commands and returns array data.
    modport master (
        output req, op, addr, wdata, mem_rdata,
        input  ready, busy, rd_data, rd_valid, done, err,
        input  mem_addr, mem_we, mem_erase, mem_wdata
    );

    // Controller side.
    modport slave (
        input  req, op, addr, wdata, mem_rdata,
        output ready, busy, rd_data, rd_valid, done, err,
        output mem_addr, mem_we, mem_erase, mem_wdata
    );
endinterface

// File: rtl/eeprom_ctrl.sv
// rtl/eeprom_ctrl.sv - erase/program/verify sequencer for a 16x16 EEPROM array
module eeprom_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 16,
    parameter int ERASE_CYCLES = 4,
    parameter int PROG_CYCLES  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    eeprom_ctrl_if.slave bus
);
    localparam int CNT_MAX = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_PROGRAM, S_VERIFY, S_READ, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_write_q, is_write_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              err_next;

    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_erase_q, mem_erase_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // State, phase timer, latched command and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_write_q  <= 1'b0;
            exp_q       <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_erase_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            exp_q       <= exp_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_erase_q <= mem_erase_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state: accept in IDLE, count down erase/program phases, verify, report.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        exp_d      = exp_q;
        err_next   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    is_write_d = (bus.op == 2'b01);
                    // Erase-only verifies against the erased value of zero.
                    exp_d      = (bus.op == 2'b01) ? bus.wdata : '0;
                    case (bus.op)
                        2'b00: state_d = S_READ;
                        2'b01, 2'b10: begin
                            state_d = S_ERASE;
                            cnt_d   = CNT_W'(ERASE_CYCLES - 1);
                        end
                        default: begin
                            state_d  = S_DONE;
                            err_next = 1'b1;
                        end
                    endcase
                end
            end
            S_ERASE: begin
                if (cnt_q == '0) begin
                    if (is_write_q) begin
                        state_d = S_PROGRAM;
                        cnt_d   = CNT_W'(PROG_CYCLES - 1);
                    end else begin
                        state_d = S_VERIFY;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PROGRAM: begin
                if (cnt_q == '0) state_d = S_VERIFY;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_VERIFY: begin
                state_d  = S_DONE;
                err_next = (bus.mem_rdata != exp_q);
            end
            S_READ:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so every strobe is a flop.
    always_comb begin
        ready_d     = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        err_d       = err_next;
        rd_valid_d  = (state_q == S_READ);
        rd_data_d   = (state_q == S_READ) ? bus.mem_rdata : rd_data_q;
        mem_addr_d  = (state_q == S_IDLE && bus.req) ? bus.addr : mem_addr_q;
        mem_erase_d = (state_d == S_ERASE);
        mem_we_d    = (state_d == S_PROGRAM);
        mem_wdata_d = (state_d == S_PROGRAM) ? exp_d : '0;
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_erase = mem_erase_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/eeprom_ctrl.md
Name: eeprom_ctrl

Overview:
Sequencing controller placed directly upstream of the 16x16 EEPROM array. It converts single-request read/write/erase commands into timed strobe sequences on the array's combinational port (addr, we, erase_enable, write_data, data). Writes always erase the word first, then program it. Every write and erase is followed by a read-back verify, and the result is reported on err.

Parameters:
ADDR_W, 4, array address width (16 words).
DATA_W, 16, array word width.
ERASE_CYCLES, 4, cycles mem_erase is held high per erase phase; must be >= 1.
PROG_CYCLES, 8, cycles mem_we is held high per program phase; must be >= 1.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req  in  1  command request; accepted on a rising edge when req && ready.
op  in  2  command code: 00 read, 01 write (erase + program), 10 erase only, 11 reserved.
addr  in  ADDR_W  target word address.
wdata  in  DATA_W  write data, used only for op 01.
ready  out  1  high only in IDLE.
busy  out  1  equals ~ready.
rd_data  out  DATA_W  last read result.
rd_valid  out  1  one-cycle pulse when rd_data updates.
done  out  1  one-cycle completion pulse for every accepted command.
err  out  1  valid only with done: verify mismatch or reserved op.
mem_addr  out  ADDR_W  drives array addr.
mem_we  out  1  drives array we.
mem_erase  out  1  drives array erase_enable.
mem_wdata  out  DATA_W  drives array write_data.
mem_rdata  in  DATA_W  array data output.

Behaviour:
- Reset (async assert, sync release): state IDLE; ready=1; busy, done, err, rd_valid, mem_we, mem_erase = 0; rd_data, mem_addr, mem_wdata = 0.
- All outputs are registered. mem_we and mem_erase are never high in the same cycle.
- Accept: in IDLE with req=1, latch op, addr and wdata at the edge. ready drops the next cycle. Input changes after the accept edge are ignored.
- req while busy: ignored. No queueing.
- States: IDLE, ERASE, PROGRAM, VERIFY, READ, DONE. A down-counter times ERASE and PROGRAM.
- Cycle numbering below: the accept edge ends cycle 0.
- op 01 (write):
  - ERASE cycles 1..E: mem_erase=1.
  - PROGRAM cycles E+1..E+P: mem_we=1, mem_wdata=latched wdata.
  - VERIFY cycle E+P+1: both strobes low; compare mem_rdata against latched wdata.
  - DONE cycle E+P+2: done=1; err=mismatch.
  - Defaults give done in cycle 14.
- op 10 (erase only): ERASE cycles 1..E, then VERIFY (expect 0), then DONE. Defaults give done in cycle 6.
- op 00 (read):
  - READ cycle 1: strobes low, mem_addr=addr; mem_rdata is captured into rd_data at the end of the cycle.
  - DONE cycle 2: done=1, rd_valid=1, err=0.
- op 11: go straight to DONE in cycle 1 with err=1. No array access.
- mem_addr holds the latched address from cycle 1 until the next accept.
- DONE always returns to IDLE the next cycle. ready=1 in cycle after DONE; back-to-back commands are possible from that cycle.
- Reset mid-operation: strobes drop immediately (async); state returns to IDLE; no done pulse. Contents of the word being written or erased are undefined afterwards.
- err and rd_valid are low outside the DONE cycle. rd_data holds its value until the next read.

Test Plan:
1. Array preloaded with 0x10+i; read addr 5 → rd_data=0x0015, with rd_valid and done both high in cycle 2 only; err=0.
2. Write addr 3, data 0xBEEF (defaults) → mem_erase high in cycles 1-4, mem_we high in cycles 5-12 with mem_wdata=0xBEEF, done in cycle 14 with err=0. A following read of addr 3 returns 0xBEEF.
3. Erase addr 15 → done in cycle 6 with err=0. A following read of addr 15 returns 0x0000.
4. Write addr 2 = 0x1234, then pulse req with read addr 9 during cycles 3-10 → second request ignored, ready=0 throughout, exactly one done pulse. Array addr 9 still reads 0x0019.
5. Bench model forces mem_rdata=0x0000 during VERIFY of a write of 0x1234 → done with err=1. op=11 → done in cycle 1 with err=1, and mem_we and mem_erase never asserted.
6. Assert rst_n low in cycle 7 of a write → mem_we falls with no clock edge, no done pulse. After release, ready=1 and a read of addr 0 returns 0x0010 in cycle 2.
